// File: rtl/divider_inverse_param.sv
// divider_inverse_param: sequential shift-add quotient*divisor+remainder with strt/idle handshake
module divider_inverse_param #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strt,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
  output logic [2*WIDTH-1:0]   result,
  output logic                 not_valid,
  output logic                 overflow,
  output logic                 idle
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t               r_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_div;
  logic [COUNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_last;
  // one accumulate step: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_last     = r_cnt == COUNT_W'(WIDTH - 1);
  end
  // latch operands on start, iterate WIDTH steps, publish result on the final step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      result    <= '0;
      not_valid <= 1'b0;
      overflow  <= 1'b0;
      idle      <= 1'b1;
    end else if (r_state == IDLE) begin
      if (strt) begin
        r_acc    <= {{WIDTH{1'b0}}, remainder};
        r_mcand  <= {{WIDTH{1'b0}}, divisor};
        r_mplier <= quotient;
        r_rem    <= remainder;
        r_div    <= divisor;
        r_cnt    <= '0;
        idle     <= 1'b0;
        r_state  <= CALC;
      end
    end else begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        result    <= w_acc_next;
        not_valid <= r_rem >= r_div;
        overflow  <= |w_acc_next[2*WIDTH-1:WIDTH];
        idle      <= 1'b1;
        r_state   <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_divider_inverse_param.sv
// tb_divider_inverse_param: randomized and directed checks against an arithmetic reference model
module tb_divider_inverse_param;
  localparam int W = 8;
  logic           clk = 0;
  logic           rst = 1;
  logic           strt = 0;
  logic [W-1:0]   quotient = 0, divisor = 0, remainder = 0;
  logic [2*W-1:0] result;
  logic           not_valid, overflow, idle;
  int             checks = 0, failures = 0;

  divider_inverse_param #(.WIDTH(W), .COUNT_W(3)) dut (
    .clk(clk), .rst(rst), .strt(strt), .quotient(quotient), .divisor(divisor),
    .remainder(remainder), .result(result), .not_valid(not_valid),
    .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [W-1:0] q, d, r, output int lat,
                        output logic [2*W-1:0] res, output logic nv, ov);
    @(negedge clk);
    quotient = q; divisor = d; remainder = r; strt = 1;
    @(negedge clk);
    strt = 0;
    lat = 0;
    while (!idle && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    res = result; nv = not_valid; ov = overflow;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] q, d, r);
    int lat, exp;
    logic [2*W-1:0] res;
    logic nv, ov;
    run_op(q, d, r, lat, res, nv, ov);
    exp = int'(q) * int'(d) + int'(r);
    checks += 4;
    if (lat !== W) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, W); end
    if (res !== 16'(exp)) begin failures++; $display("FAIL %s result q=%0d d=%0d r=%0d got=%0d exp=%0d", name, q, d, r, res, exp); end
    if (nv !== (r >= d)) begin failures++; $display("FAIL %s not_valid got=%0b exp=%0b", name, nv, r >= d); end
    if (ov !== (exp > 255)) begin failures++; $display("FAIL %s overflow got=%0b exp=%0b", name, ov, exp > 255); end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({result, not_valid, overflow, idle} !== {16'd0, 3'b001}) begin
      failures++;
      $display("FAIL reset got res=%0d nv=%0b ov=%0b idle=%0b exp 0/0/0/1", result, not_valid, overflow, idle);
    end
    rst = 0;
  endtask

  task automatic test_directed;
    check_op("sq5", 5, 5, 0);
    check_op("d12", 12, 11, 10);
    check_op("d2", 2, 91, 18);
    check_op("nv1", 1, 91, 109);
    check_op("max", 255, 255, 254);
    check_op("q0", 0, 21, 0);
    check_op("div0", 7, 0, 96);
    check_op("div0q0", 0, 0, 255);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] q, d, r;
      q = W'($urandom);
      d = (i % 8 == 0) ? '0 : W'($urandom);
      r = W'($urandom);
      check_op("rand", q, d, r);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_idle;
    int rises = 0;
    logic prev;
    @(negedge clk);
    quotient = 3; divisor = 21; remainder = 18; strt = 1;
    prev = idle;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 9) strt = 0;
      exp_idle = (i == 8) || (i >= 17);
      checks++;
      if (idle !== exp_idle) begin failures++; $display("FAIL b2b idle[%0d] got=%0b exp=%0b", i, idle, exp_idle); end
      if (idle && !prev) begin
        rises++;
        checks++;
        if (result !== 16'd81) begin failures++; $display("FAIL b2b result got=%0d exp=81", result); end
      end
      prev = idle;
    end
    checks++;
    if (rises !== 2) begin failures++; $display("FAIL b2b completions got=%0d exp=2", rises); end
  endtask

  task automatic test_midchange;
    int lat = 0;
    @(negedge clk);
    quotient = 10; divisor = 20; remainder = 0; strt = 1;
    @(negedge clk);
    strt = 0;
    repeat (2) @(negedge clk);
    quotient = 99; divisor = 55; remainder = 3;
    while (!idle && lat < 100) begin lat++; @(negedge clk); end
    checks++;
    if (result !== 16'd200 || not_valid !== 1'b0) begin
      failures++;
      $display("FAIL midchange got res=%0d nv=%0b exp res=200 nv=0", result, not_valid);
    end
  endtask

  task automatic test_midreset;
    @(negedge clk);
    quotient = 200; divisor = 3; remainder = 1; strt = 1;
    @(negedge clk);
    strt = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if ({result, not_valid, overflow, idle} !== {16'd0, 3'b001}) begin
      failures++;
      $display("FAIL midreset got res=%0d nv=%0b ov=%0b idle=%0b exp 0/0/0/1", result, not_valid, overflow, idle);
    end
    rst = 0;
    repeat (12) @(negedge clk);
    checks++;
    if (idle !== 1'b1 || result !== 16'd0) begin
      failures++;
      $display("FAIL midreset_nocompl got res=%0d idle=%0b exp res=0 idle=1", result, idle);
    end
  endtask

  task automatic test_loopback;
    for (int i = 0; i < 15; i++) begin
      int dv, d, lat;
      logic [2*W-1:0] res;
      logic nv, ov;
      dv = int'($urandom_range(0, 255));
      d  = int'($urandom_range(1, 255));
      run_op(W'(dv / d), W'(d), W'(dv % d), lat, res, nv, ov);
      checks++;
      if (res !== 16'(dv) || nv !== 1'b0 || ov !== 1'b0) begin
        failures++;
        $display("FAIL loopback dividend=%0d divisor=%0d got res=%0d nv=%0b ov=%0b", dv, d, res, nv, ov);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_midchange;
    test_midreset;
    test_loopback;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/divider_inverse_param.md
Name: divider_inverse_param

Overview:
Sequential shift-add multiply-accumulate block. It reconstructs the dividend from a divider result triple: result = quotient * divisor + remainder. It is the reverse direction of the divider blocks and uses the same strt/idle handshake, so divider outputs can be wired straight into it for self-checking. It also serves as a general-purpose unsigned multiplier with a per-operation addend.

Parameters:
WIDTH, 8, operand width in bits (quotient, divisor, remainder).
COUNT_W, 3, bit-counter width; must equal log2(WIDTH).

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset, synchronous, active-high.
strt  input  1  start request, level-sensitive, sampled only while idle=1.
quotient  input  WIDTH  multiplier operand.
divisor  input  WIDTH  multiplicand operand.
remainder  input  WIDTH  addend.
result  output  2*WIDTH  quotient*divisor+remainder; registered.
not_valid  output  1  the triple is not a legal divider result: remainder >= divisor, which includes divisor == 0.
overflow  output  1  result[2*WIDTH-1:WIDTH] != 0, i.e. the reconstructed dividend does not fit in WIDTH bits.
idle  output  1  1 = ready or done, 0 = busy.

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-operation):
  - result=0, not_valid=0, overflow=0, idle=1.
  - FSM goes to IDLE and the bit counter clears.
  - rst has priority over strt.
- FSM states are IDLE and CALC.
- IDLE, at an edge with strt=1:
  - Latch the operands: acc = zero-extended remainder, mcand = zero-extended divisor, mplier = quotient, cnt = 0.
  - idle <= 0; go to CALC.
- IDLE, at an edge with strt=0: hold all state.
- CALC, each edge:
  - If mplier[0]=1, acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, cnt += 1.
  - When cnt == WIDTH-1 on entry, that is the last step.
- Last CALC step:
  - result <= final acc.
  - not_valid <= (latched remainder >= latched divisor).
  - overflow <= (final acc upper half != 0).
  - idle <= 1; go to IDLE.
- Latency:
  - idle is low for exactly WIDTH cycles after the edge that sampled strt.
  - result, not_valid and overflow update on the same edge that idle rises.
- Outputs hold their previous values during CALC. They change only at completion or on reset.
- Input changes during CALC are ignored; operands are latched at start.
- strt held high: a new operation starts on the first edge with idle=1. Back-to-back operations show idle=1 for one cycle between them.
- Width: acc is 2*WIDTH bits. The maximum (2^W-1)^2 + (2^W-1) = 2^2W - 2^W never wraps; no carry out is needed.
- divisor=0: result = remainder, not_valid=1, overflow=0.
- quotient=0: result = remainder after the full WIDTH cycles. There is no early termination.
- The computation is always completed; not_valid does not suppress result.

Test Plan:
- W=8, q=5, d=5, r=0, pulse strt for 1 cycle -> idle low exactly 8 cycles; result=25, not_valid=0, overflow=0.
- q=12, d=11, r=10 -> result=142, valid. Then q=2, d=91, r=18 -> 200, valid. Then q=1, d=91, r=109 -> 200, not_valid=1.
- q=255, d=255, r=254 -> result=65279 (0xFEFF), overflow=1, not_valid=0. Then q=0, d=21, r=0 -> result=0, overflow=0.
- d=0, q=7, r=96 -> result=96, not_valid=1.
- strt held high 10 cycles with q=3, d=21, r=18 -> two back-to-back results of 81, with idle high for a single cycle between them.
- Mid-operation cases:
  - Start q=10, d=20, r=0; change inputs to 99/55/3 three cycles later -> result=200.
  - Separate run: assert rst 4 cycles into an operation -> next edge gives idle=1 and result=0, and no completion follows.
- Loopback: chain divider_param #(8,3) outputs into this block for the divider's directed vectors -> result equals the original dividend whenever the divider's not_valid=0.
